// File: rtl/stream_fifo_pkg.sv
// Project-wide defaults and helpers shared by the stream FIFO files.
package stream_fifo_pkg;

  localparam int unsigned FE_DATA_W      = 8;
  localparam int unsigned FIFO_DEPTH     = 16;
  localparam int unsigned FIFO_AFULL_TH  = FIFO_DEPTH - 2;
  localparam int unsigned FIFO_AEMPTY_TH = 1;

  // Pointer width carries one extra wrap bit above the memory index.
  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FE_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with occupancy flags, flush, error pulses and a
// selectable first-word-fall-through or registered-output read stage.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = FE_DATA_W,
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = FIFO_AEMPTY_TH,
  parameter int unsigned FWFT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam logic [PtrW-1:0] AfullTh  = PtrW'(AFULL_TH);
  localparam logic [PtrW-1:0] AemptyTh = PtrW'(AEMPTY_TH);

  logic [PtrW-1:0]   w_ptr_q, w_ptr_d;
  logic [PtrW-1:0]   r_ptr_q, r_ptr_d;
  logic [PtrW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, push, pop, ram_we;
  logic [DATA_W-1:0] rd_data;

  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[AddrW-1:0] == r_ptr_q[AddrW-1:0]) &&
                 (w_ptr_q[AddrW] != r_ptr_q[AddrW]);

  // in_ready is purely registered, so a pop while full cannot free a slot this cycle.
  assign push   = in_valid_i & ~full;
  assign pop    = out_ready_i & ~empty;
  assign ram_we = push & ~clear_i;

  always_comb begin
    w_ptr_d    = w_ptr_q;
    r_ptr_d    = r_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (clear_i) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      overflow_d = in_valid_i & full;
      if (push) w_ptr_d = w_ptr_q + PtrW'(1);
      if (pop)  r_ptr_d = r_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + PtrW'(1);
        2'b01:   count_d = count_q - PtrW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(w_ptr_q[AddrW-1:0]),
    .wdata_i(in_data_i),
    .raddr_i(r_ptr_q[AddrW-1:0]),
    .rdata_o(rd_data)
  );

  assign in_ready_o     = ~full;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= AfullTh);
  assign almost_empty_o = (count_q <= AemptyTh);
  assign overflow_o     = overflow_q;

  if (FWFT != 0) begin : g_fwft
    assign out_valid_o = ~empty;
    assign out_data_o  = rd_data;
    assign underflow_o = 1'b0;
  end else begin : g_regout
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              underflow_q, underflow_d;

    always_comb begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      underflow_d = 1'b0;
      if (clear_i) begin
        out_data_d = '0;
      end else begin
        out_valid_d = pop;
        underflow_d = out_ready_i & empty;
        if (pop) out_data_d = rd_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        underflow_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
        underflow_q <= underflow_d;
      end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign underflow_o = underflow_q;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench: one FWFT and one registered-output FIFO against queue models.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr = 0, a_iv = 0, a_or = 0;
  logic [7:0] a_id = 0;
  logic       a_ir, a_ov, a_af, a_ae, a_ovf, a_unf;
  logic [7:0] a_od;
  logic [4:0] a_cnt;

  logic       b_clr = 0, b_iv = 0, b_or = 0;
  logic [7:0] b_id = 0;
  logic       b_ir, b_ov, b_af, b_ae, b_ovf, b_unf;
  logic [7:0] b_od;
  logic [4:0] b_cnt;

  stream_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clear_i(a_clr), .in_valid_i(a_iv), .in_ready_o(a_ir),
    .in_data_i(a_id), .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
    .count_o(a_cnt), .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ovf),
    .underflow_o(a_unf)
  );

  stream_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(1), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .clear_i(b_clr), .in_valid_i(b_iv), .in_ready_o(b_ir),
    .in_data_i(b_id), .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
    .count_o(b_cnt), .almost_full_o(b_af), .almost_empty_o(b_ae), .overflow_o(b_ovf),
    .underflow_o(b_unf)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       ova_e = 0, ovb_e = 0, vb_e = 0, ub_e = 0;
  logic [7:0] db_e = 0;

  localparam logic [10:0] ResetVec = 11'b1_0_00000_0_1_0_0;

  function automatic logic [10:0] exp_a();
    int s = qa.size();
    return {s < 16, s != 0, 5'(s), s >= 14, s <= 1, ova_e, 1'b0};
  endfunction

  function automatic logic [10:0] exp_b();
    int s = qb.size();
    return {s < 16, vb_e, 5'(s), s >= 14, s <= 1, ovb_e, ub_e};
  endfunction

  function automatic void model_reset();
    qa.delete(); qb.delete();
    ova_e = 0; ovb_e = 0; vb_e = 0; ub_e = 0; db_e = 0;
  endfunction

  // Advance the models with the current inputs, then clock once; returns at negedge.
  task automatic tick();
    bit fa, fb, pa, pb, poa, pob;
    fa  = (qa.size() == 16);
    pa  = a_iv && !fa;
    poa = a_or && qa.size() != 0;
    ova_e = !a_clr && a_iv && fa;
    if (a_clr) qa.delete();
    else begin
      if (poa) void'(qa.pop_front());
      if (pa) qa.push_back(a_id);
    end
    fb  = (qb.size() == 16);
    pb  = b_iv && !fb;
    pob = b_or && qb.size() != 0;
    if (b_clr) begin
      qb.delete(); vb_e = 0; db_e = 0; ub_e = 0; ovb_e = 0;
    end else begin
      ovb_e = b_iv && fb;
      ub_e  = b_or && qb.size() == 0;
      vb_e  = pob;
      if (pob) db_e = qb.pop_front();
      if (pb) qb.push_back(b_id);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_clr = 0; a_iv = 0; a_or = 0; b_clr = 0; b_iv = 0; b_or = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({a_ir, a_ov, a_cnt, a_af, a_ae, a_ovf, a_unf} !== ResetVec) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected %b", {a_ir, a_ov, a_cnt, a_af, a_ae, a_ovf, a_unf},
               ResetVec);
    end
    n_checks++;
    if ({b_ir, b_ov, b_cnt, b_af, b_ae, b_ovf, b_unf, b_od} !== {ResetVec, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected %b",
               {b_ir, b_ov, b_cnt, b_af, b_ae, b_ovf, b_unf, b_od}, {ResetVec, 8'h00});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      a_iv = 1; a_id = 8'(i); a_or = 0;
      tick();
      n_checks++;
      if ({a_cnt, a_af, a_ir} !== {5'(i), i >= 14, i < 16}) begin
        n_fail++;
        $display("FAIL fill_%0d cnt/af/ir: got %b expected %b", i, {a_cnt, a_af, a_ir},
                 {5'(i), i >= 14, i < 16});
      end
    end
    a_id = 8'h55;
    tick();
    n_checks++;
    if ({a_ovf, a_cnt} !== {1'b1, 5'd16}) begin
      n_fail++;
      $display("FAIL overflow_pulse: got %b expected %b", {a_ovf, a_cnt}, {1'b1, 5'd16});
    end
    // Pop while full must not admit the offered word.
    a_id = 8'h99; a_or = 1;
    tick();
    n_checks++;
    if ({a_ovf, a_cnt} !== {1'b1, 5'd15}) begin
      n_fail++;
      $display("FAIL full_pop_push: got %b expected %b", {a_ovf, a_cnt}, {1'b1, 5'd15});
    end
    a_iv = 0;
    for (int j = 2; j <= 16; j++) begin
      n_checks++;
      if ({a_ov, a_od} !== {1'b1, 8'(j)}) begin
        n_fail++;
        $display("FAIL drain_%0d: got %h expected %h", j, {a_ov, a_od}, {1'b1, 8'(j)});
      end
      tick();
    end
    a_or = 0;
    n_checks++;
    if ({a_cnt, a_ae, a_ov, a_ovf} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_end: got %b expected %b", {a_cnt, a_ae, a_ov, a_ovf}, 8'b0000_0100);
    end
  endtask

  task automatic test_fwft();
    a_iv = 1; a_id = 8'hA5;
    tick();
    a_iv = 0;
    n_checks++;
    if ({a_ov, a_od, a_cnt} !== {1'b1, 8'hA5, 5'd1}) begin
      n_fail++;
      $display("FAIL fwft_head: got %h expected %h", {a_ov, a_od, a_cnt}, {1'b1, 8'hA5, 5'd1});
    end
    a_or = 1;
    tick();
    a_or = 0;
    n_checks++;
    if ({a_ov, a_cnt, a_ae} !== {1'b0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL fwft_pop: got %b expected %b", {a_ov, a_cnt, a_ae}, 7'b0000001);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      a_iv = 1; a_id = 8'($urandom);
      tick();
    end
    a_or = 1;
    for (int i = 0; i < 40; i++) begin
      a_id = 8'($urandom);
      tick();
      n_checks++;
      if ({a_cnt, a_ov, a_od} !== {5'd3, 1'b1, qa[0]}) begin
        n_fail++;
        $display("FAIL stream_%0d: got %h expected %h", i, {a_cnt, a_ov, a_od},
                 {5'd3, 1'b1, qa[0]});
      end
    end
    a_iv = 0;
    repeat (3) tick();
    a_or = 0;
    n_checks++;
    if (a_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL stream_drain: got %0d expected 0", a_cnt);
    end
  endtask

  task automatic test_regout();
    b_iv = 1; b_id = 8'h11; tick();
    b_id = 8'h22; tick();
    b_iv = 0; b_or = 1;
    tick();
    n_checks++;
    if ({b_ov, b_od, b_unf} !== {1'b1, 8'h11, 1'b0}) begin
      n_fail++;
      $display("FAIL regout_first: got %h expected %h", {b_ov, b_od, b_unf}, {1'b1, 8'h11, 1'b0});
    end
    tick();
    n_checks++;
    if ({b_ov, b_od, b_unf} !== {1'b1, 8'h22, 1'b0}) begin
      n_fail++;
      $display("FAIL regout_second: got %h expected %h", {b_ov, b_od, b_unf},
               {1'b1, 8'h22, 1'b0});
    end
    tick();
    n_checks++;
    if ({b_ov, b_od, b_unf} !== {1'b0, 8'h22, 1'b1}) begin
      n_fail++;
      $display("FAIL underflow_pulse: got %h expected %h", {b_ov, b_od, b_unf},
               {1'b0, 8'h22, 1'b1});
    end
    b_or = 0;
    tick();
    n_checks++;
    if ({b_ov, b_od, b_unf, b_cnt} !== {1'b0, 8'h22, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL underflow_end: got %h expected %h", {b_ov, b_od, b_unf, b_cnt},
               {1'b0, 8'h22, 1'b0, 5'd0});
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) begin
      a_iv = 1; b_iv = 1; a_id = 8'(8'h30 + i); b_id = 8'(8'h40 + i);
      tick();
    end
    a_clr = 1; b_clr = 1; a_or = 1; b_or = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({a_cnt, a_ov, b_cnt, b_ov, b_od} !== {5'd0, 1'b0, 5'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL clear_state: got %h expected 0", {a_cnt, a_ov, b_cnt, b_ov, b_od});
    end
    tick();
    n_checks++;
    if ({a_cnt, b_cnt, a_ae, b_ae} !== {5'd0, 5'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_hold: got %b expected %b", {a_cnt, b_cnt, a_ae, b_ae}, 12'b11);
    end
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 100) % 2 == 0) ? 80 : 25;
      a_iv  = ($urandom_range(0, 99) < wp);
      a_or  = ($urandom_range(0, 99) < 50);
      a_clr = ($urandom_range(0, 99) < 2);
      a_id  = 8'($urandom);
      b_iv  = ($urandom_range(0, 99) < wp);
      b_or  = ($urandom_range(0, 99) < 50);
      b_clr = ($urandom_range(0, 99) < 2);
      b_id  = 8'($urandom);
      tick();
      n_checks++;
      if ({a_ir, a_ov, a_cnt, a_af, a_ae, a_ovf, a_unf} !== exp_a()) begin
        n_fail++;
        $display("FAIL rand_a_flags %0d: got %b expected %b", i,
                 {a_ir, a_ov, a_cnt, a_af, a_ae, a_ovf, a_unf}, exp_a());
      end
      if (qa.size() != 0) begin
        n_checks++;
        if (a_od !== qa[0]) begin
          n_fail++;
          $display("FAIL rand_a_data %0d: got %h expected %h", i, a_od, qa[0]);
        end
      end
      n_checks++;
      if ({b_ir, b_ov, b_cnt, b_af, b_ae, b_ovf, b_unf, b_od} !== {exp_b(), db_e}) begin
        n_fail++;
        $display("FAIL rand_b %0d: got %b expected %b", i,
                 {b_ir, b_ov, b_cnt, b_af, b_ae, b_ovf, b_unf, b_od}, {exp_b(), db_e});
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    a_clr = 1; b_clr = 1; tick(); idle_inputs();
    for (int i = 0; i < 9; i++) begin
      a_iv = 1; b_iv = 1; a_id = 8'($urandom); b_id = 8'($urandom);
      tick();
    end
    idle_inputs();
    b_or = 1; tick(); b_or = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({a_ir, a_ov, a_cnt, a_af, a_ae, a_ovf, a_unf} !== ResetVec) begin
      n_fail++;
      $display("FAIL async_reset_a: got %b expected %b",
               {a_ir, a_ov, a_cnt, a_af, a_ae, a_ovf, a_unf}, ResetVec);
    end
    n_checks++;
    if ({b_ir, b_ov, b_cnt, b_af, b_ae, b_ovf, b_unf, b_od} !== {ResetVec, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset_b: got %b expected %b",
               {b_ir, b_ov, b_cnt, b_af, b_ae, b_ovf, b_unf, b_od}, {ResetVec, 8'h00});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_iv = 1; b_iv = 1; a_id = 8'h7E; b_id = 8'h7E;
    tick();
    idle_inputs();
    n_checks++;
    if ({a_ov, a_od, a_cnt} !== {1'b1, 8'h7E, 5'd1}) begin
      n_fail++;
      $display("FAIL post_reset_a: got %h expected %h", {a_ov, a_od, a_cnt}, {1'b1, 8'h7E, 5'd1});
    end
    b_or = 1; tick(); b_or = 0;
    n_checks++;
    if ({b_ov, b_od, b_cnt} !== {1'b1, 8'h7E, 5'd0}) begin
      n_fail++;
      $display("FAIL post_reset_b: got %h expected %h", {b_ov, b_od, b_cnt}, {1'b1, 8'h7E, 5'd0});
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_fwft();
    test_back_to_back();
    test_regout();
    test_clear();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO for the front-end datapath, sitting between producer and consumer stages. It supports:
- a valid/ready handshake on both sides;
- full-depth capacity;
- an occupancy count with almost-full/almost-empty thresholds;
- a synchronous flush;
- overflow/underflow error pulses.

A mode parameter selects first-word-fall-through (FWFT) or registered-output behaviour, so existing read-enable consumers can migrate without change.

## Interface
- DATA_W, default `FE_DATA_W`: payload width in bits.
- DEPTH, default `FIFO_DEPTH`: entries. Must be a power of two and ≥ 2.
- AFULL_TH, default DEPTH-2: almost_full asserts when count ≥ AFULL_TH.
- AEMPTY_TH, default 1: almost_empty asserts when count ≤ AEMPTY_TH.
- FWFT, default 1: 1 = head word visible on out_data; 0 = registered-output mode.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous flush.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept; equals !full.
- in_data  in  DATA_W  write payload.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer takes or requests a word.
- out_data  out  DATA_W  read payload.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- overflow  out  1  one-cycle pulse on a rejected write.
- underflow  out  1  one-cycle pulse on a read while empty (FWFT=0 only).

## Operation
**Pointers and flags**
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- empty: pointers equal.
- full: low bits equal and MSB differs.
- All DEPTH entries are usable.

**Push, pop, count**
- push = in_valid & in_ready.
- pop = out_ready & !empty.
- count is registered: +1 on push only, −1 on pop only, unchanged on push & pop.
- in_ready depends only on registered state (no combinational path from out_ready). Consequently, when full a same-cycle pop does not enable a push.

**Data output by mode**
- FWFT=1: out_valid = !empty. out_data = mem[r_ptr] (asynchronous read), don't-care while out_valid=0. underflow is tied to 0.
- FWFT=0: on pop, out_data <= mem[r_ptr] and out_valid pulses 1 for the next cycle. Otherwise out_data holds and out_valid=0. out_ready with empty=1 → underflow pulse next cycle; out_data and r_ptr unchanged.

**Errors**
- overflow pulses one cycle after in_valid & !in_ready. The rejected data is dropped.

**Clear**
- Zeroes pointers, count, overflow, underflow and out_valid.
- In FWFT=0, also zeroes out_data.
- Memory is not cleared.
- Overrides push/pop in the same cycle.

**Reset**
- Same state as clear, applied asynchronously.
- Output values after reset: in_ready=1, out_valid=0, out_data=0 (FWFT=0), count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.

## Timing
- Write latency: a push at edge N is visible at N+1: count, out_valid (FWFT=1), flags.
- Read latency: FWFT=1 has zero cycles (head already on out_data). FWFT=0 has one cycle (pop at N, data at N+1).
- Push and pop in the same cycle with count=0: pop is not possible (empty), so only the push is taken.
- Push and pop in the same cycle with 0<count<DEPTH: both are taken, count unchanged, pointers advance mod 2·DEPTH.
- Pointer wrap-around is seamless. The memory index uses the low bits.
- almost_full and almost_empty are combinational from count, so they update together with count.
- reset deassertion: the first push is accepted at the first clk edge after rst_n rises.

## Structure
- constants.vh: `FE_DATA_W`, `FIFO_DEPTH`; add `FIFO_AFULL_TH` and `FIFO_AEMPTY_TH` as project defaults.
- Sub-module fifo_ram: DEPTH×DATA_W simple dual-port memory, synchronous write, asynchronous read.
- Control (pointers, count, flags, mode output stage) lives in stream_fifo.

## Test plan
- Reset, then push 0x01..0x10 with out_ready=0 (DATA_W=8, DEPTH=16) → count=16, in_ready=0, almost_full=1 from count 14. A 17th push → overflow pulse, count stays 16.
- FWFT=1: push 0xA5 with the FIFO empty → next cycle out_valid=1, out_data=0xA5. Pop → out_valid=0, count=0, almost_empty=1.
- Continuous push+pop of 40 words at count=3 → count stays 3, data order preserved across two pointer wraps.
- FWFT=0: push 0x11,0x22, then pulse out_ready for 2 cycles → out_data=0x11 then 0x22, each with a one-cycle out_valid. A third out_ready → underflow pulse, out_data stays 0x22.
- clear together with push and pop at count=5 → next cycle count=0, out_valid=0, push ignored.
- Assert rst_n low mid-stream at count=9 → outputs at reset values immediately (asynchronously). After release, push 0x7E → it is read back first.
